// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types, defaults and count-to-LED helper for the vote display controller
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        RESULT = 2'd2,
        SCAN   = 2'd3
    } vote_state_t;

    localparam int DEF_NUM_CAND    = 4;
    localparam int DEF_VOTE_W      = 8;
    localparam int DEF_LED_W       = 8;
    localparam int DEF_HOLD_CYCLES = 100000000;

    // Widest count or LED bus the helper below can carry.
    localparam int MAX_W = 64;

    // Fits a count onto led_w LEDs: zero-extend when it fits, saturate to all
    // ones when a bit above the LED range is set.
    function automatic logic [MAX_W-1:0] count_to_led(
        input logic [MAX_W-1:0] count,
        input int               vote_w,
        input int               led_w
    );
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} >> (MAX_W - led_w);
        if ((vote_w > led_w) && ((count & ~mask) != '0)) begin
            return mask;
        end
        return count & mask;
    endfunction

endpackage

// File: rtl/vote_max_scan.sv
// rtl/vote_max_scan.sv - sequential argmax and tie scanner, one candidate per cycle
module vote_max_scan
    import vote_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int VOTE_W   = DEF_VOTE_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CAND*VOTE_W-1:0]   votes_flat,
    output logic                         done,
    output logic [$clog2(NUM_CAND)-1:0]  idx,
    output logic                         tie
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    logic [VOTE_W-1:0] cand [NUM_CAND];
    logic              busy_q;
    logic [IDX_W-1:0]  scan_idx_q;
    logic [VOTE_W-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tie_q;

    logic [VOTE_W-1:0] cur;
    logic [VOTE_W-1:0] max_n;
    logic [IDX_W-1:0]  idx_n;
    logic              tie_n;

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_unpack
        assign cand[g] = votes_flat[g*VOTE_W +: VOTE_W];
    end

    // Strictly greater takes over; equality only raises the tie flag, so the
    // lowest index holding the maximum is the one reported.
    always_comb begin
        cur   = cand[scan_idx_q];
        max_n = max_q;
        idx_n = idx_q;
        tie_n = tie_q;
        if (scan_idx_q == '0) begin
            max_n = cur;
            idx_n = '0;
            tie_n = 1'b0;
        end else if (cur > max_q) begin
            max_n = cur;
            idx_n = scan_idx_q;
            tie_n = 1'b0;
        end else if (cur == max_q) begin
            tie_n = 1'b1;
        end
    end

    assign done = busy_q && (scan_idx_q == LAST_IDX);
    assign idx  = idx_n;
    assign tie  = tie_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            scan_idx_q <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            tie_q      <= 1'b0;
        end else if (start) begin
            busy_q     <= 1'b1;
            scan_idx_q <= '0;
        end else if (busy_q) begin
            max_q <= max_n;
            idx_q <= idx_n;
            tie_q <= tie_n;
            if (done) begin
                busy_q <= 1'b0;
            end else begin
                scan_idx_q <= scan_idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/vote_display_ctrl.sv
// rtl/vote_display_ctrl.sv - voting/result mode controller driving the board LEDs
module vote_display_ctrl
    import vote_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int VOTE_W      = DEF_VOTE_W,
    parameter int LED_W       = DEF_LED_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0]   votes_flat,
    input  logic [NUM_CAND-1:0]          button_press,
    output logic [LED_W-1:0]             leds,
    output logic                         ack_busy,
    output logic [$clog2(NUM_CAND)-1:0]  winner_idx,
    output logic                         winner_valid,
    output logic                         tie
);

    localparam int IDX_W   = $clog2(NUM_CAND);
    localparam int TIMER_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);

    vote_state_t state_q, state_n;
    logic [TIMER_W-1:0]        timer_q, timer_n;
    logic [LED_W-1:0]          leds_n;
    logic                      ack_busy_n;
    logic [IDX_W-1:0]          win_idx_n;
    logic                      win_valid_n;
    logic                      tie_n;
    logic                      scan_start;
    logic [NUM_CAND*VOTE_W-1:0] snapshot_q;
    logic                      changed_q;

    logic                      scan_done;
    logic [IDX_W-1:0]          scan_idx;
    logic                      scan_tie;

    logic                      btn_any;
    logic [VOTE_W-1:0]         btn_count;
    logic [LED_W-1:0]          btn_leds;

    vote_max_scan #(
        .NUM_CAND (NUM_CAND),
        .VOTE_W   (VOTE_W)
    ) u_scan (
        .clock      (clock),
        .reset      (reset),
        .start      (scan_start),
        .votes_flat (snapshot_q),
        .done       (scan_done),
        .idx        (scan_idx),
        .tie        (scan_tie)
    );

    // Walk downwards so the lowest pressed button ends up selected.
    always_comb begin
        btn_any   = 1'b0;
        btn_count = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (button_press[i]) begin
                btn_any   = 1'b1;
                btn_count = votes_flat[i*VOTE_W +: VOTE_W];
            end
        end
    end

    assign btn_leds = LED_W'(count_to_led(MAX_W'(btn_count), VOTE_W, LED_W));

    always_comb begin
        state_n     = state_q;
        timer_n     = timer_q;
        leds_n      = leds;
        win_idx_n   = winner_idx;
        win_valid_n = winner_valid;
        tie_n       = tie;
        scan_start  = 1'b0;
        case (state_q)
            IDLE: begin
                leds_n = '0;
                if (mode) begin
                    state_n    = SCAN;
                    scan_start = 1'b1;
                end else if (valid_vote_casted) begin
                    state_n = ACK;
                    timer_n = TIMER_LOAD;
                    leds_n  = '1;
                end
            end
            ACK: begin
                leds_n = '1;
                if (mode) begin
                    state_n    = SCAN;
                    scan_start = 1'b1;
                    timer_n    = '0;
                    leds_n     = '0;
                end else if (valid_vote_casted) begin
                    timer_n = TIMER_LOAD;
                end else if (timer_q == '0) begin
                    state_n = IDLE;
                    leds_n  = '0;
                end else begin
                    timer_n = timer_q - TIMER_W'(1);
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_n     = IDLE;
                    leds_n      = '0;
                    win_valid_n = 1'b0;
                end else if (changed_q) begin
                    scan_start = 1'b1;
                end else if (scan_done) begin
                    state_n     = RESULT;
                    win_valid_n = 1'b1;
                    win_idx_n   = scan_idx;
                    tie_n       = scan_tie;
                end
            end
            RESULT: begin
                if (!mode) begin
                    state_n     = IDLE;
                    leds_n      = '0;
                    win_valid_n = 1'b0;
                end else begin
                    if (btn_any) begin
                        leds_n = btn_leds;
                    end
                    if (changed_q) begin
                        state_n     = SCAN;
                        scan_start  = 1'b1;
                        win_valid_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                leds_n  = '0;
            end
        endcase
        ack_busy_n = (state_n == ACK);
    end

    // The change flag is cleared on every scan start so a stale compare
    // against the previous snapshot never retriggers the new scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            leds         <= '0;
            ack_busy     <= 1'b0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            snapshot_q   <= '0;
            changed_q    <= 1'b0;
        end else begin
            state_q      <= state_n;
            timer_q      <= timer_n;
            leds         <= leds_n;
            ack_busy     <= ack_busy_n;
            winner_idx   <= win_idx_n;
            winner_valid <= win_valid_n;
            tie          <= tie_n;
            if (scan_start) begin
                snapshot_q <= votes_flat;
                changed_q  <= 1'b0;
            end else begin
                changed_q  <= (votes_flat != snapshot_q);
            end
        end
    end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// tb/tb_vote_display_ctrl.sv - self-checking bench for vote_display_ctrl
module tb_vote_display_ctrl;

    localparam int NC    = 4;
    localparam int VW    = 8;
    localparam int LW    = 8;
    localparam int HOLD  = 5;
    localparam int VWB   = 10;
    localparam int HOLDB = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic            mode = 1'b0;
    logic            valid = 1'b0;
    logic [NC*VW-1:0] votes = '0;
    logic [NC-1:0]   btn = '0;
    logic [LW-1:0]   leds;
    logic            ack_busy;
    logic [1:0]      widx;
    logic            wv;
    logic            tie;

    logic             mode_b = 1'b1;
    logic [NC*VWB-1:0] votes_b = '0;
    logic [NC-1:0]    btn_b = '0;
    logic [LW-1:0]    leds_b;
    logic             ack_busy_b;
    logic [1:0]       widx_b;
    logic             wv_b;
    logic             tie_b;

    int checks = 0;
    int errors = 0;
    int cnt [NC];
    int cnt_b [NC];

    always #5 clock = ~clock;

    vote_display_ctrl #(
        .NUM_CAND(NC), .VOTE_W(VW), .LED_W(LW), .HOLD_CYCLES(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .valid_vote_casted(valid),
        .votes_flat(votes), .button_press(btn), .leds(leds), .ack_busy(ack_busy),
        .winner_idx(widx), .winner_valid(wv), .tie(tie)
    );

    vote_display_ctrl #(
        .NUM_CAND(NC), .VOTE_W(VWB), .LED_W(LW), .HOLD_CYCLES(HOLDB)
    ) dut_b (
        .clock(clock), .reset(reset), .mode(mode_b), .valid_vote_casted(1'b0),
        .votes_flat(votes_b), .button_press(btn_b), .leds(leds_b), .ack_busy(ack_busy_b),
        .winner_idx(widx_b), .winner_valid(wv_b), .tie(tie_b)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_votes;
        for (int i = 0; i < NC; i++) votes[i*VW +: VW] = VW'(cnt[i]);
    endtask

    task automatic set_votes_b;
        for (int i = 0; i < NC; i++) votes_b[i*VWB +: VWB] = VWB'(cnt_b[i]);
    endtask

    // Reference: largest count, first index holding it, tie when held more than once.
    task automatic model_winner(output int m_idx, output bit m_tie);
        int mx = -1;
        int n = 0;
        m_idx = 0;
        for (int i = 0; i < NC; i++) if (cnt[i] > mx) mx = cnt[i];
        for (int i = NC - 1; i >= 0; i--) if (cnt[i] == mx) begin m_idx = i; n++; end
        m_tie = (n > 1);
    endtask

    task automatic wait_wv(output bit ok);
        int n = 0;
        while (wv !== 1'b1 && n < 40) begin tick; n++; end
        ok = (wv === 1'b1);
    endtask

    task automatic wait_wv_b(output bit ok);
        int n = 0;
        while (wv_b !== 1'b1 && n < 40) begin tick; n++; end
        ok = (wv_b === 1'b1);
    endtask

    // Lit cycles after a pulse at cycle p are p+1 .. p+HOLD, restarted by each pulse.
    task automatic run_voting(input int n, input logic [63:0] pulses, input string name);
        int last = -1000;
        logic exp_on;
        for (int k = 0; k < n + HOLD + 1; k++) begin
            valid = (k < n) ? pulses[k] : 1'b0;
            if (valid) last = k;
            tick;
            exp_on = ((k + 1 - last) <= HOLD);
            checks++;
            if ({leds, ack_busy} !== {(exp_on ? 8'hFF : 8'h00), exp_on}) begin
                errors++;
                $display("FAIL %s cycle %0d: leds=%h ack_busy=%b expected leds=%h ack_busy=%b",
                         name, k + 1, leds, ack_busy, (exp_on ? 8'hFF : 8'h00), exp_on);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++;
        if ({leds, ack_busy, widx, wv, tie} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {leds, ack_busy, widx, wv, tie});
        end
        reset = 1'b1;
    endtask

    task automatic test_ack_hold;
        run_voting(20, 64'h1 << 10, "ack_single");
    endtask

    task automatic test_ack_retrigger;
        run_voting(20, (64'h1 << 10) | (64'h1 << 13), "ack_retrigger");
    endtask

    task automatic test_ack_random;
        logic [63:0] p;
        for (int r = 0; r < 3; r++) begin
            p = '0;
            for (int i = 0; i < 40; i++) p[i] = ($urandom_range(0, 5) == 0);
            run_voting(40, p, "ack_random");
        end
    endtask

    task automatic test_ack_abort;
        bit ok;
        valid = 1'b1; tick; valid = 1'b0; tick;
        mode = 1'b1; valid = 1'b1; tick; valid = 1'b0;
        checks++;
        if ({leds, ack_busy} !== 9'h0) begin
            errors++;
            $display("FAIL ack_abort: leds=%h ack_busy=%b expected 0 0", leds, ack_busy);
        end
        wait_wv(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_scan_timeout: winner_valid=%b expected 1", wv); end
        valid = 1'b1; tick; valid = 1'b0; tick;
        checks++;
        if (ack_busy !== 1'b0) begin
            errors++;
            $display("FAIL result_ignores_vote: ack_busy=%b expected 0", ack_busy);
        end
        mode = 1'b0; tick;
    endtask

    task automatic test_scan;
        int m_idx;
        bit m_tie;
        bit ok;
        int j;
        int old;
        cnt = '{3, 9, 9, 1};
        set_votes;
        tick;
        mode = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick;
            if (i == 4) begin
                checks++;
                if (wv !== 1'b0) begin errors++; $display("FAIL scan_early: winner_valid=%b expected 0", wv); end
            end
        end
        model_winner(m_idx, m_tie);
        checks++;
        if ({wv, widx, tie} !== {1'b1, 2'(m_idx), m_tie}) begin
            errors++;
            $display("FAIL scan_tie: valid/idx/tie=%b/%0d/%b expected 1/%0d/%b", wv, widx, tie, m_idx, m_tie);
        end
        for (int r = 0; r < 7; r++) begin
            if (r == 0) begin
                cnt[2] = 10;
            end else begin
                j = $urandom_range(0, NC - 1);
                old = cnt[j];
                for (int i = 0; i < NC; i++) cnt[i] = $urandom_range(0, 7);
                cnt[j] = (old + $urandom_range(1, 7)) % 8;
            end
            set_votes;
            tick;
            tick;
            checks++;
            if (wv !== 1'b0) begin errors++; $display("FAIL change_drop %0d: winner_valid=%b expected 0", r, wv); end
            wait_wv(ok);
            model_winner(m_idx, m_tie);
            checks++;
            if (!ok || widx !== 2'(m_idx) || tie !== m_tie) begin
                errors++;
                $display("FAIL rescan %0d: valid/idx/tie=%b/%0d/%b expected 1/%0d/%b", r, wv, widx, tie, m_idx, m_tie);
            end
        end
    endtask

    task automatic test_buttons;
        int sel;
        btn = 4'b0110; tick;
        checks++;
        if (leds !== LW'(cnt[1])) begin errors++; $display("FAIL btn_0110: leds=%h expected %h", leds, LW'(cnt[1])); end
        btn = 4'b0000; tick; tick; tick;
        checks++;
        if (leds !== LW'(cnt[1])) begin errors++; $display("FAIL btn_release: leds=%h expected %h", leds, LW'(cnt[1])); end
        btn = 4'b1000; tick;
        checks++;
        if (leds !== LW'(cnt[3])) begin errors++; $display("FAIL btn_1000: leds=%h expected %h", leds, LW'(cnt[3])); end
        for (int r = 0; r < 8; r++) begin
            btn = 4'($urandom_range(1, 15));
            sel = 0;
            while (!btn[sel]) sel++;
            tick;
            checks++;
            if (leds !== LW'(cnt[sel])) begin
                errors++;
                $display("FAIL btn_random %b: leds=%h expected %h", btn, leds, LW'(cnt[sel]));
            end
        end
        btn = '0;
    endtask

    task automatic test_mode_exit;
        int m_idx;
        bit m_tie;
        model_winner(m_idx, m_tie);
        mode = 1'b0; tick;
        checks++;
        if ({leds, wv, widx, tie} !== {8'h00, 1'b0, 2'(m_idx), m_tie}) begin
            errors++;
            $display("FAIL mode_exit: leds=%h valid=%b idx=%0d tie=%b expected 00 0 %0d %b", leds, wv, widx, tie, m_idx, m_tie);
        end
    endtask

    task automatic test_saturate;
        bit ok;
        int v;
        logic [LW-1:0] exp_l;
        wait_wv_b(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_scan_timeout: winner_valid=%b expected 1", wv_b); end
        btn_b = 4'b0001;
        for (int r = 0; r < 8; r++) begin
            if (r == 0) v = 300;
            else if (r == 1) v = 200;
            else begin
                v = $urandom_range(0, 1023);
                if (v == cnt_b[0]) v = (v + 1) % 1024;
            end
            cnt_b[0] = v;
            set_votes_b;
            tick;
            exp_l = (v > 255) ? 8'hFF : LW'(v);
            checks++;
            if (leds_b !== exp_l) begin
                errors++;
                $display("FAIL saturate count %0d: leds=%h expected %h", v, leds_b, exp_l);
            end
            tick;
            wait_wv_b(ok);
        end
        btn_b = '0;
    endtask

    task automatic test_reset_mid_ack;
        valid = 1'b1; tick; valid = 1'b0; tick;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({leds, ack_busy, widx, wv, tie, leds_b, ack_busy_b, widx_b, wv_b, tie_b} !== '0) begin
            errors++;
            $display("FAIL async_reset: a=%h b=%h expected 0", {leds, ack_busy, widx, wv, tie},
                     {leds_b, ack_busy_b, widx_b, wv_b, tie_b});
        end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++;
            if ({leds, ack_busy} !== 9'h0) begin
                errors++;
                $display("FAIL after_reset cycle %0d: leds=%h ack_busy=%b expected 0 0", i, leds, ack_busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin cnt[i] = 0; cnt_b[i] = 0; end
        test_reset;
        test_ack_hold;
        test_ack_retrigger;
        test_ack_random;
        test_ack_abort;
        test_scan;
        test_buttons;
        test_mode_exit;
        test_saturate;
        test_reset_mid_ack;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
